morse_tx: RTL and testbench

Morse transmitter for the key-entry path. It takes a 5-bit letter code (0 = A … 25 = Z) and plays that letter on a single on/off `key` line (LED/buzzer) using standard Morse timing. It sits after the code-capture/decode stage, so the board can echo or replay entered characters. Sequencing uses a small FSM, a unit-time counter and a symbol shift register.

---
 rtl/morse_tx.sv | 152 +++++++++++++++
 tb/tb_morse_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/morse_tx.sv
// morse_tx: plays one A-Z letter code as ITU Morse on a single on/off key line
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start, code  - request to send letter code (0=A .. 25=Z), sampled only when idle
//   key          - Morse output, 1 = tone/light on
//   busy         - character in progress (marks, inter-symbol spaces and trailing gap)
//   done         - one-cycle pulse after the trailing gap completes
//   err          - one-cycle pulse when start arrives with code 26..31
//   cur_sym      - kind of current/last mark, 0 = dot, 1 = dash
module morse_tx #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] code,
    output logic       key,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cur_sym
);
    localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] U1 = CW'(UNIT_CYCLES);
    localparam logic [CW-1:0] U3 = CW'(3 * UNIT_CYCLES);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, CGAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    pat, pat_n;
    logic [2:0]    rem, rem_n;
    logic          key_n, busy_n, done_n, err_n, sym_n;
    logic [6:0]    rom;

    // {len, pattern}: pattern is MSB-first, 1 = dash, unused low bits zero
    always_comb begin
        rom = 7'd0;
        case (code)
            5'd0:  rom = {3'd2, 4'b0100};
            5'd1:  rom = {3'd4, 4'b1000};
            5'd2:  rom = {3'd4, 4'b1010};
            5'd3:  rom = {3'd3, 4'b1000};
            5'd4:  rom = {3'd1, 4'b0000};
            5'd5:  rom = {3'd4, 4'b0010};
            5'd6:  rom = {3'd3, 4'b1100};
            5'd7:  rom = {3'd4, 4'b0000};
            5'd8:  rom = {3'd2, 4'b0000};
            5'd9:  rom = {3'd4, 4'b0111};
            5'd10: rom = {3'd3, 4'b1010};
            5'd11: rom = {3'd4, 4'b0100};
            5'd12: rom = {3'd2, 4'b1100};
            5'd13: rom = {3'd2, 4'b1000};
            5'd14: rom = {3'd3, 4'b1110};
            5'd15: rom = {3'd4, 4'b0110};
            5'd16: rom = {3'd4, 4'b1101};
            5'd17: rom = {3'd3, 4'b0100};
            5'd18: rom = {3'd3, 4'b0000};
            5'd19: rom = {3'd1, 4'b1000};
            5'd20: rom = {3'd3, 4'b0010};
            5'd21: rom = {3'd4, 4'b0001};
            5'd22: rom = {3'd3, 4'b0110};
            5'd23: rom = {3'd4, 4'b1001};
            5'd24: rom = {3'd4, 4'b1011};
            5'd25: rom = {3'd4, 4'b1100};
            default: rom = 7'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pat     <= '0;
            rem     <= '0;
            key     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cur_sym <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pat     <= pat_n;
            rem     <= rem_n;
            key     <= key_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            cur_sym <= sym_n;
        end
    end

    // cnt holds the remaining cycles of the current interval; cnt==1 marks its last cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pat_n   = pat;
        rem_n   = rem;
        key_n   = key;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        sym_n   = cur_sym;
        case (state)
            IDLE: begin
                if (start && code <= 5'd25) begin
                    state_n = MARK;
                    pat_n   = rom[3:0];
                    rem_n   = rom[6:4];
                    cnt_n   = rom[3] ? U3 : U1;
                    key_n   = 1'b1;
                    busy_n  = 1'b1;
                    sym_n   = rom[3];
                end else if (start) begin
                    err_n = 1'b1;
                end
            end
            MARK: begin
                if (cnt == CW'(1)) begin
                    key_n   = 1'b0;
                    state_n = (rem > 3'd1) ? SPACE : CGAP;
                    cnt_n   = (rem > 3'd1) ? U1 : U3;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SPACE: begin
                if (cnt == CW'(1)) begin
                    state_n = MARK;
                    pat_n   = {pat[2:0], 1'b0};
                    rem_n   = rem - 3'd1;
                    key_n   = 1'b1;
                    sym_n   = pat[2];
                    cnt_n   = pat[2] ? U3 : U1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            CGAP: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: scoreboard bench for morse_tx with hand-computed expected characters
module tb_morse_tx;
    localparam int UC = 4;
    localparam int K_CHAR = 0, K_ERR = 1, K_ABORT = 2;

    typedef struct {
        int         kind;
        int         nsym;
        logic [3:0] pat;
        int         busy;
        int         start_cyc;
        bit         b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] code = 5'd0;
    logic       key, busy, done, err, cur_sym;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    morse_tx #(.UNIT_CYCLES(UC)) dut (
        .clk(clk), .reset(reset), .start(start), .code(code),
        .key(key), .busy(busy), .done(done), .err(err), .cur_sym(cur_sym)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor state
    exp_t e;
    int   bc, nm, on_len, off_len, scyc, sym;
    bit   pbusy = 0, pkey = 0, pdone = 0, sdone, fell;
    int   ml[8];
    bit   ms[8];

    always @(negedge clk) begin
        if (mon_en) begin
            fell = pbusy && !busy;
            if (err) begin
                if (q.size() == 0) chk(0, "err_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk(e.kind == K_ERR, "err_kind", K_ERR, e.kind);
                    chk(!busy && !key, "err_idle", {busy, key}, 0);
                end
            end
            if (busy && !pbusy) begin
                bc = 0; nm = 0; on_len = 0; off_len = 0; scyc = cyc; sdone = pdone;
            end
            if (busy) begin
                bc++;
                if (key) begin
                    if (!pkey && pbusy) chk(off_len == UC, "space_len", off_len, UC);
                    off_len = 0;
                    on_len++;
                    if (nm < 8) ms[nm] = cur_sym;
                end else begin
                    if (pkey) begin
                        if (nm < 8) ml[nm] = on_len;
                        nm++;
                        on_len = 0;
                    end
                    off_len++;
                end
            end
            if (fell) begin
                if (q.size() == 0) chk(0, "end_unexpected", done, 0);
                else begin
                    e = q.pop_front();
                    if (done) begin
                        chk(e.kind == K_CHAR, "done_kind", K_CHAR, e.kind);
                        chk(bc == e.busy, "busy_len", bc, e.busy);
                        chk(nm == e.nsym, "mark_count", nm, e.nsym);
                        for (int i = 0; i < e.nsym && i < 8; i++) begin
                            sym = int'(e.pat[e.nsym-1-i]);
                            chk(ml[i] == (sym != 0 ? 3 * UC : UC), "mark_len", ml[i], sym != 0 ? 3 * UC : UC);
                            chk(int'(ms[i]) == sym, "cur_sym", int'(ms[i]), sym);
                        end
                        if (e.b2b) chk(sdone, "b2b_start", int'(sdone), 1);
                        else chk(scyc == e.start_cyc, "start_latency", scyc, e.start_cyc);
                    end else begin
                        chk(e.kind == K_ABORT, "abort_kind", K_ABORT, e.kind);
                        chk(!key, "abort_key", int'(key), 0);
                    end
                end
            end else if (done) begin
                chk(0, "done_stray", 1, 0);
            end
            pbusy = busy; pkey = key; pdone = done;
        end
    end

    task automatic push(input int kind, input int nsym, input logic [3:0] pat, input int bz, input bit b2b);
        exp_t x;
        x.kind = kind; x.nsym = nsym; x.pat = pat; x.busy = bz;
        x.start_cyc = cyc + 1; x.b2b = b2b;
        q.push_back(x);
    endtask

    task automatic pulse(input logic [4:0] c);
        code = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] c, input int kind, input int nsym, input logic [3:0] pat, input int bz);
        @(posedge clk); #1;
        push(kind, nsym, pat, bz, 1'b0);
        pulse(c);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 400 && !(q.size() == 0 && !busy)) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) chk(0, {"timeout_", name}, q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk(key == 1'b0, "reset_key", int'(key), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(done == 1'b0, "reset_done", int'(done), 0);
        chk(err == 1'b0, "reset_err", int'(err), 0);
        chk(cur_sym == 1'b0, "reset_cur_sym", int'(cur_sym), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk({key, busy, done, err, cur_sym} == 5'b0, "idle_quiet", {key, busy, done, err, cur_sym}, 0);
        mon_en = 1'b1;

        send(5'd4, K_CHAR, 1, 4'b0000, 16);       // E  .
        wait_idle("E");
        send(5'd0, K_CHAR, 2, 4'b0001, 32);       // A  .-
        wait_idle("A");
        send(5'd16, K_CHAR, 4, 4'b1101, 64);      // Q  --.-
        repeat (10) @(posedge clk);
        #1 pulse(5'd4);
        code = 5'd1;
        repeat (20) @(posedge clk);
        #1 pulse(5'd31);
        wait_idle("Q");
        send(5'd27, K_ERR, 0, 4'b0000, 0);        // invalid
        wait_idle("invalid");
        send(5'd19, K_CHAR, 1, 4'b0001, 24);      // T  -
        wait_idle("T");

        send(5'd19, K_ABORT, 1, 4'b0001, 24);     // T aborted in its dash
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        wait_idle("abort");

        @(posedge clk); #1;
        push(K_CHAR, 1, 4'b0000, 16, 1'b0);
        push(K_CHAR, 1, 4'b0000, 16, 1'b1);
        code = 5'd4;
        start = 1'b1;
        begin
            int n = 0;
            while (n < 100 && !done) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk(0, "timeout_b2b_done", 0, 1);
        end
        @(posedge clk); #1 start = 1'b0;
        wait_idle("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
